// File: rtl/lfsr_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// lfsr_seq_ctrl_if
// Command and status bundle for the lfsr_seq_ctrl sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : valid/ready command channel (host -> ctrl)
//   q, busy, done, period, period_valid, err : status reported by the controller
// master : host / test controller side
// slave  : sequencer side
// -----------------------------------------------------------------------------
interface lfsr_seq_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_data;
  logic [5:0]       q;
  logic             busy;
  logic             done;
  logic [5:0]       period;
  logic             period_valid;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, q, busy, done, period, period_valid, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, q, busy, done, period, period_valid, err
  );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_seq_ctrl
// Command-driven sequencer around a 6-bit Galois LFSR. Operations:
//   LOAD (00) seed, STEP (01) one advance, RUN (10) N advances,
//   MEASURE (11) count advances until the state returns to its start value.
// Ports:
//   clk   : clock, rising edge
//   rst_b : asynchronous active-low reset
//   bus   : lfsr_seq_ctrl_if slave modport (command channel + status)
// -----------------------------------------------------------------------------
module lfsr_seq_ctrl #(
  parameter logic [5:0] TAPS     = 6'b001000,
  parameter logic [5:0] SEED_RST = 6'h3F,
  parameter int         CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  lfsr_seq_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_MEAS = 2'b11;

  // A 6-bit LFSR cannot revisit its start state later than 63 advances;
  // reaching the 63rd advance without a match means the measurement failed.
  localparam logic [5:0] PCNT_LAST = 6'd62;

  state_t           state_q, state_d;
  logic [5:0]       q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       meas_ref_q, meas_ref_d;
  logic [5:0]       pcnt_q, pcnt_d;
  logic [5:0]       period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [5:0]       q_adv;
  logic             accept;

  // One Galois advance: the msb is fed back into bit 0 and into every
  // tapped position; bit 0 of TAPS has no effect.
  assign q_adv[0] = q_q[5];
  generate
    for (genvar gi = 1; gi < 6; gi++) begin : g_adv
      assign q_adv[gi] = q_q[gi-1] ^ (TAPS[gi] & q_q[5]);
    end
  endgenerate

  assign accept = bus.cmd_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d        = state_q;
    q_d            = q_q;
    cnt_d          = cnt_q;
    meas_ref_d     = meas_ref_q;
    pcnt_d         = pcnt_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    err_d          = err_q;
    done_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d = 1'b0;
          case (bus.cmd_op)
            OP_LOAD: begin
              // An all-zero seed would lock the register up, so refuse it.
              if (bus.cmd_data[5:0] == 6'd0) begin
                err_d = 1'b1;
              end else begin
                q_d = bus.cmd_data[5:0];
              end
              period_valid_d = 1'b0;
              done_d         = 1'b1;
            end
            OP_STEP: begin
              cnt_d   = CNT_W'(1);
              state_d = ST_RUN;
            end
            OP_RUN: begin
              if (bus.cmd_data == '0) begin
                done_d = 1'b1;
              end else begin
                cnt_d   = bus.cmd_data;
                state_d = ST_RUN;
              end
            end
            default: begin // OP_MEAS
              meas_ref_d     = q_q;
              pcnt_d         = 6'd0;
              period_valid_d = 1'b0;
              state_d        = ST_MEAS;
            end
          endcase
        end
      end

      ST_RUN: begin
        q_d   = q_adv;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      ST_MEAS: begin
        q_d    = q_adv;
        pcnt_d = pcnt_q + 6'd1;
        // Compare the value about to be loaded, so q lands back on the
        // reference at the completing edge.
        if (q_adv == meas_ref_q) begin
          period_d       = pcnt_q + 6'd1;
          period_valid_d = 1'b1;
          state_d        = ST_IDLE;
          done_d         = 1'b1;
        end else if (pcnt_q == PCNT_LAST) begin
          err_d          = 1'b1;
          period_valid_d = 1'b0;
          state_d        = ST_IDLE;
          done_d         = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= ST_IDLE;
      q_q            <= SEED_RST;
      cnt_q          <= '0;
      meas_ref_q     <= 6'd0;
      pcnt_q         <= 6'd0;
      period_q       <= 6'd0;
      period_valid_q <= 1'b0;
      err_q          <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      q_q            <= q_d;
      cnt_q          <= cnt_d;
      meas_ref_q     <= meas_ref_d;
      pcnt_q         <= pcnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      err_q          <= err_d;
      done_q         <= done_d;
    end
  end

  assign bus.cmd_ready    = (state_q == ST_IDLE);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.q            = q_q;
  assign bus.done         = done_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lfsr_seq_ctrl
// Scoreboard bench for lfsr_seq_ctrl: every issued command pushes its expected
// completion (latency, busy cycles, q, err, period, period_valid) computed by a
// behavioural model; the entry is popped and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_lfsr_seq_ctrl;

  localparam logic [5:0] TAPS_TB = 6'b001000;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_MEAS = 2'b11;

  typedef struct {
    logic [1:0] op;
    int         lat;
    int         busy_n;
    logic [5:0] q;
    logic       err;
    logic       pv;
    logic [5:0] period;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  lfsr_seq_ctrl_if #(.CNT_W(8)) bus();

  lfsr_seq_ctrl #(
    .TAPS    (TAPS_TB),
    .SEED_RST(6'h3F),
    .CNT_W   (8)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Behavioural model state
  logic [5:0] m_q;
  logic       m_err;
  logic       m_pv;
  logic [5:0] m_period;

  // Galois step written as rotate-left then xor of the tap mask when the msb was set.
  function automatic logic [5:0] model_next(input logic [5:0] v);
    logic [5:0] r;
    r = {v[4:0], v[5]};
    if (v[5]) r = r ^ (TAPS_TB & 6'b111110);
    return r;
  endfunction

  task automatic model_reset();
    m_q = 6'h3F; m_err = 1'b0; m_pv = 1'b0; m_period = 6'd0;
  endtask

  // Compute expected completion, push it, and present the command for one edge.
  // Called at a sampling point (#1 after a rising edge) while the DUT is idle.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
    exp_t e;
    int   n;
    logic [5:0] r;
    e.op = op;
    case (op)
      OP_LOAD: begin
        if (data[5:0] == 6'd0) m_err = 1'b1;
        else begin m_q = data[5:0]; m_err = 1'b0; end
        m_pv = 1'b0; e.lat = 0; e.busy_n = 0;
      end
      OP_STEP, OP_RUN: begin
        n = (op == OP_STEP) ? 1 : int'(data);
        for (int i = 0; i < n; i++) m_q = model_next(m_q);
        m_err = 1'b0; e.lat = n; e.busy_n = n;
      end
      default: begin
        r = m_q; m_err = 1'b0; m_pv = 1'b0; e.lat = 63;
        for (int i = 1; i <= 63; i++) begin
          m_q = model_next(m_q);
          if (m_q == r) begin m_period = 6'(i); m_pv = 1'b1; e.lat = i; break; end
        end
        if (!m_pv) m_err = 1'b1;
        e.busy_n = e.lat;
      end
    endcase
    e.q = m_q; e.err = m_err; e.pv = m_pv; e.period = m_period;
    sb.push_back(e);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for done, optionally pulsing ignored LOAD commands while busy.
  task automatic wait_done(input bit noise, input string name);
    int   k = 0;
    int   busy_n = 0;
    bit   seen = 0;
    exp_t e;
    while (k <= 400) begin
      if (bus.done) begin seen = 1; break; end
      if (bus.busy) busy_n++;
      if (noise && bus.busy) begin
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
          errors++; $display("FAIL %s ready_while_busy: got %b expected 0", name, bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_LOAD; bus.cmd_data = 8'h2A;
      end
      @(posedge clk); #1; k++;
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s done_timeout: got no done expected done", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s scoreboard_empty: got done expected no done", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (k !== e.lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, k, e.lat); end
    checks++;
    if (busy_n !== e.busy_n) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, e.busy_n); end
    checks++;
    if (bus.q !== e.q) begin errors++; $display("FAIL %s q: got %h expected %h", name, bus.q, e.q); end
    checks++;
    if (bus.err !== e.err) begin errors++; $display("FAIL %s err: got %b expected %b", name, bus.err, e.err); end
    checks++;
    if (bus.period_valid !== e.pv) begin errors++; $display("FAIL %s period_valid: got %b expected %b", name, bus.period_valid, e.pv); end
    checks++;
    if (bus.period !== e.period) begin errors++; $display("FAIL %s period: got %0d expected %0d", name, bus.period, e.period); end
    $display("txn %-10s op=%0d lat=%0d busy=%0d q=%h err=%b period=%0d pv=%b", name, e.op, k, busy_n, bus.q, bus.err, bus.period, bus.period_valid);
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk); #1;
    model_reset();
    checks++;
    if (bus.q !== 6'h3F) begin errors++; $display("FAIL reset_q: got %h expected 3f", bus.q); end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready); end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", bus.busy, bus.done); end
    checks++;
    if (bus.err !== 1'b0 || bus.period_valid !== 1'b0 || bus.period !== 6'd0) begin
      errors++; $display("FAIL reset_status: got err=%b pv=%b period=%0d expected 0 0 0", bus.err, bus.period_valid, bus.period);
    end
    $display("txn reset      q=%h ready=%b", bus.q, bus.cmd_ready);
  endtask

  task automatic test_step();
    logic [5:0] plan [4];
    plan[0] = 6'h37; plan[1] = 6'h27; plan[2] = 6'h07; plan[3] = 6'h0E;
    for (int i = 0; i < 4; i++) begin
      send_cmd(OP_STEP, 8'h00);
      wait_done(1'b0, "step");
      checks++;
      if (bus.q !== plan[i]) begin errors++; $display("FAIL step_plan_%0d: got %h expected %h", i, bus.q, plan[i]); end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL step_done_width: got %b expected 0", bus.done); end
    end
  endtask

  task automatic test_measure();
    send_cmd(OP_LOAD, 8'h3F);
    wait_done(1'b0, "load");
    send_cmd(OP_MEAS, 8'h00);
    wait_done(1'b0, "measure");
    checks++;
    if (bus.period !== 6'd9 || bus.q !== 6'h3F) begin
      errors++; $display("FAIL measure_plan: got period=%0d q=%h expected 9 3f", bus.period, bus.q);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL measure_done_width: got %b expected 0", bus.done); end
    send_cmd(OP_LOAD, 8'h0E);
    wait_done(1'b0, "load");
    checks++;
    if (bus.period_valid !== 1'b0) begin errors++; $display("FAIL load_clears_pv: got %b expected 0", bus.period_valid); end
    send_cmd(OP_MEAS, 8'h00);
    wait_done(1'b0, "measure");
  endtask

  task automatic test_run();
    send_cmd(OP_LOAD, 8'h3F);
    wait_done(1'b0, "load");
    send_cmd(OP_RUN, 8'd18);
    wait_done(1'b1, "run18");
    checks++;
    if (bus.q !== 6'h3F) begin errors++; $display("FAIL run18_q: got %h expected 3f", bus.q); end
    send_cmd(OP_RUN, 8'd0);
    wait_done(1'b0, "run0");
    send_cmd(OP_RUN, 8'd5);
    wait_done(1'b0, "run5");
  endtask

  task automatic test_load_err();
    send_cmd(OP_LOAD, 8'h00);
    wait_done(1'b0, "load0");
    send_cmd(OP_LOAD, 8'h15);
    wait_done(1'b0, "load15");
    checks++;
    if (bus.q !== 6'h15 || bus.err !== 1'b0) begin
      errors++; $display("FAIL load15_plan: got q=%h err=%b expected 15 0", bus.q, bus.err);
    end
  endtask

  // Next command is presented in the done cycle itself.
  task automatic test_back_to_back();
    send_cmd(OP_STEP, 8'h00);
    wait_done(1'b0, "b2b_step");
    send_cmd(OP_RUN, 8'd3);
    wait_done(1'b0, "b2b_run3");
    send_cmd(OP_MEAS, 8'h00);
    wait_done(1'b0, "b2b_meas");
  endtask

  task automatic test_reset_mid();
    send_cmd(OP_RUN, 8'd200);
    repeat (49) begin @(posedge clk); #1; end
    @(negedge clk) rst_b = 1'b0;
    #1;
    sb.delete();
    model_reset();
    checks++;
    if (bus.q !== 6'h3F || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid: got q=%h busy=%b ready=%b expected 3f 0 1", bus.q, bus.busy, bus.cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_mid_done: got %b expected 0", bus.done); end
    end
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk); #1;
    $display("txn reset_mid  q=%h busy=%b", bus.q, bus.busy);
    send_cmd(OP_STEP, 8'h00);
    wait_done(1'b0, "post_rst");
    checks++;
    if (bus.q !== 6'h37) begin errors++; $display("FAIL post_reset_step: got %h expected 37", bus.q); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'h00;
    model_reset();
    test_reset();
    test_step();
    test_measure();
    test_run();
    test_load_err();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
